// File: rtl/lock_keypad_if.sv
// Keypad-to-lock-controller bundle: keystroke inputs and the registered
// request/status outputs of lock_keypad.
interface lock_keypad_if #(
  parameter int MAX_FAILS = 3
);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  logic              key_valid;
  logic [3:0]        key_digit;
  logic              key_enter;
  logic              key_close;
  logic              open;
  logic              close;
  logic              locked_out;
  logic [FAIL_W-1:0] fail_count;
  logic [3:0]        entry_count;

  modport master (
    output key_valid, key_digit, key_enter, key_close,
    input  open, close, locked_out, fail_count, entry_count
  );

  modport slave (
    input  key_valid, key_digit, key_enter, key_close,
    output open, close, locked_out, fail_count, entry_count
  );
endinterface

// File: rtl/lock_keypad.sv
// Keypad front-end: buffers digits, compares against a fixed code, emits
// open/close pulses, and enforces wrong-code lockout and idle-entry timeout.
module lock_keypad #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] CODE           = 16'h1234,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    LOCKOUT_CYCLES = 16,
  parameter int                    TIMEOUT_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  lock_keypad_if.slave  bus
);
  localparam int BW = 4 * CODE_LEN;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0]    CNT_FULL  = 4'(CODE_LEN);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ENTRY, LOCKOUT} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          ill_q, ill_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          open_q, open_d;
  logic          close_q, close_d;

  logic          match;
  logic [FW-1:0] fail_inc;
  logic [BW+3:0] shifted;

  assign match    = (cnt_q == CNT_FULL) && !ovf_q && !ill_q && (buf_q == CODE);
  assign fail_inc = fail_q + 1'b1;
  assign shifted  = {buf_q, bus.key_digit};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
      fail_q  <= '0;
      lock_q  <= '0;
      idle_q  <= '0;
      open_q  <= 1'b0;
      close_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
      fail_q  <= fail_d;
      lock_q  <= lock_d;
      idle_q  <= idle_d;
      open_q  <= open_d;
      close_q <= close_d;
    end
  end

  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    fail_d  = fail_q;
    lock_d  = lock_q;
    idle_d  = idle_q;
    open_d  = 1'b0;
    close_d = 1'b0;

    // Lockout timer runs independently of any key activity, including close.
    if (state_q == LOCKOUT) begin
      if (lock_q == LOCK_LAST) begin
        state_d = IDLE;
        fail_d  = '0;
        lock_d  = '0;
      end else begin
        lock_d = lock_q + 1'b1;
      end
    end

    if (bus.key_close) begin
      close_d = 1'b1;
      buf_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      ill_d   = 1'b0;
      idle_d  = '0;
      if (state_q != LOCKOUT) state_d = IDLE;
    end else if (state_q != LOCKOUT) begin
      if (bus.key_enter) begin
        buf_d  = '0;
        cnt_d  = '0;
        ovf_d  = 1'b0;
        ill_d  = 1'b0;
        idle_d = '0;
        if (match) begin
          open_d  = 1'b1;
          fail_d  = '0;
          state_d = IDLE;
        end else begin
          fail_d = fail_inc;
          if (fail_inc == FAIL_MAX) begin
            state_d = LOCKOUT;
            lock_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end else if (bus.key_valid) begin
        // A full buffer is frozen; extra digits only poison the entry.
        if (cnt_q == CNT_FULL) begin
          ovf_d = 1'b1;
        end else begin
          buf_d = shifted[BW-1:0];
          cnt_d = cnt_q + 1'b1;
        end
        if (bus.key_digit > 4'd9) ill_d = 1'b1;
        idle_d  = '0;
        state_d = ENTRY;
      end else if (state_q == ENTRY) begin
        if (idle_q == IDLE_LAST) begin
          buf_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
          idle_d  = '0;
          state_d = IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.open        = open_q;
    bus.close       = close_q;
    bus.locked_out  = (state_q == LOCKOUT);
    bus.fail_count  = fail_q;
    bus.entry_count = cnt_q;
  end
endmodule

// File: tb/tb_lock_keypad.sv
// Directed bench for lock_keypad: a per-cycle vector table for the single-cycle
// behaviour plus hand sequences for lockout, timeout and reset-in-lockout.
module tb_lock_keypad;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lock_keypad_if kif ();

  lock_keypad dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  typedef struct {
    logic       c, e, v;
    logic [3:0] d;
    logic       op, cl, lo;
    int         fc, ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic c, logic e, logic v, logic [3:0] d,
                              logic op, logic cl, logic lo, int fc, int ec);
    vec_t r;
    r.c = c; r.e = e; r.v = v; r.d = d;
    r.op = op; r.cl = cl; r.lo = lo; r.fc = fc; r.ec = ec;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return at the next falling
  // edge so outputs reflect the edge that consumed them.
  task automatic step(input logic c, input logic e, input logic v, input logic [3:0] d);
    kif.key_close = c;
    kif.key_enter = e;
    kif.key_valid = v;
    kif.key_digit = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic digits(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    step(1'b0, 1'b0, 1'b1, a);
    step(1'b0, 1'b0, 1'b1, b);
    step(1'b0, 1'b0, 1'b1, c);
    step(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic enter();
    step(1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    kif.key_close = 1'b0;
    kif.key_enter = 1'b0;
    kif.key_valid = 1'b0;
    kif.key_digit = 4'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset open",        int'(kif.open), 0);
    check("reset close",       int'(kif.close), 0);
    check("reset locked_out",  int'(kif.locked_out), 0);
    check("reset fail_count",  int'(kif.fail_count), 0);
    check("reset entry_count", int'(kif.entry_count), 0);

    //                 c  e  v  d      op cl lo fc ec
    // correct code opens exactly one cycle after enter
    tbl.push_back(mk(0, 0, 1, 4'd1,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 4'd2,  0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 4'd3,  0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 1, 4'd4,  0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 1, 0, 4'd0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0,  0, 0, 0, 0, 0));
    // overflow: fifth digit saturates entry_count and spoils the entry
    tbl.push_back(mk(0, 0, 1, 4'd1,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 4'd2,  0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 4'd3,  0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 1, 4'd4,  0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 1, 4'd5,  0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 1, 0, 4'd0,  0, 0, 0, 1, 0));
    // illegal digit
    tbl.push_back(mk(0, 0, 1, 4'd1,  0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 4'd2,  0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 1, 4'd3,  0, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 1, 4'd11, 0, 0, 0, 1, 4));
    tbl.push_back(mk(0, 1, 0, 4'd0,  0, 0, 0, 2, 0));
    // match clears fail_count
    tbl.push_back(mk(0, 0, 1, 4'd1,  0, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 1, 4'd2,  0, 0, 0, 2, 2));
    tbl.push_back(mk(0, 0, 1, 4'd3,  0, 0, 0, 2, 3));
    tbl.push_back(mk(0, 0, 1, 4'd4,  0, 0, 0, 2, 4));
    tbl.push_back(mk(0, 1, 0, 4'd0,  1, 0, 0, 0, 0));
    // enter with no digits is a mismatch
    tbl.push_back(mk(0, 1, 0, 4'd0,  0, 0, 0, 1, 0));
    // close beats enter; buffer cleared, fail_count kept
    tbl.push_back(mk(0, 0, 1, 4'd1,  0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 4'd2,  0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 1, 4'd3,  0, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 1, 4'd4,  0, 0, 0, 1, 4));
    tbl.push_back(mk(1, 1, 0, 4'd0,  0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0,  0, 0, 0, 2, 0));
    // enter beats digit in the same cycle
    tbl.push_back(mk(0, 0, 1, 4'd1,  0, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 1, 4'd2,  0, 0, 0, 2, 2));
    tbl.push_back(mk(0, 0, 1, 4'd3,  0, 0, 0, 2, 3));
    tbl.push_back(mk(0, 0, 1, 4'd4,  0, 0, 0, 2, 4));
    tbl.push_back(mk(0, 1, 1, 4'd5,  1, 0, 0, 0, 0));
    // close beats digit
    tbl.push_back(mk(0, 0, 1, 4'd7,  0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 4'd8,  0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0,  0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].c, tbl[i].e, tbl[i].v, tbl[i].d);
      check($sformatf("row%0d open", i),        int'(kif.open),        int'(tbl[i].op));
      check($sformatf("row%0d close", i),       int'(kif.close),       int'(tbl[i].cl));
      check($sformatf("row%0d locked_out", i),  int'(kif.locked_out),  int'(tbl[i].lo));
      check($sformatf("row%0d fail_count", i),  int'(kif.fail_count),  tbl[i].fc);
      check($sformatf("row%0d entry_count", i), int'(kif.entry_count), tbl[i].ec);
    end

    // Three wrong codes -> lockout, held for exactly 16 cycles.
    for (int k = 1; k <= 3; k++) begin
      digits(4'd1, 4'd2, 4'd3, 4'd5);
      enter();
      check($sformatf("wrong%0d fail_count", k), int'(kif.fail_count), k);
      check($sformatf("wrong%0d locked_out", k), int'(kif.locked_out), (k == 3) ? 1 : 0);
    end
    // cycles 1..5 of lockout: correct code is ignored
    step(1'b0, 1'b0, 1'b1, 4'd1);
    check("lock digit entry_count", int'(kif.entry_count), 0);
    step(1'b0, 1'b0, 1'b1, 4'd2);
    step(1'b0, 1'b0, 1'b1, 4'd3);
    step(1'b0, 1'b0, 1'b1, 4'd4);
    enter();
    check("lock enter open", int'(kif.open), 0);
    check("lock enter locked_out", int'(kif.locked_out), 1);
    // cycle 6: close still pulses, lockout persists
    step(1'b1, 1'b0, 1'b0, 4'd0);
    check("lock close pulse", int'(kif.close), 1);
    check("lock close locked_out", int'(kif.locked_out), 1);
    idle(9);
    check("lock last cycle locked_out", int'(kif.locked_out), 1);
    check("lock last cycle fail_count", int'(kif.fail_count), 3);
    idle(1);
    check("lock expired locked_out", int'(kif.locked_out), 0);
    check("lock expired fail_count", int'(kif.fail_count), 0);

    // 31 idle cycles in ENTRY is still within the window.
    step(1'b0, 1'b0, 1'b1, 4'd1);
    step(1'b0, 1'b0, 1'b1, 4'd2);
    idle(31);
    check("pre-timeout entry_count", int'(kif.entry_count), 2);
    step(1'b0, 1'b0, 1'b1, 4'd3);
    step(1'b0, 1'b0, 1'b1, 4'd4);
    enter();
    check("pre-timeout open", int'(kif.open), 1);

    // 32 idle cycles discards the partial entry.
    step(1'b0, 1'b0, 1'b1, 4'd1);
    step(1'b0, 1'b0, 1'b1, 4'd2);
    idle(32);
    check("timeout entry_count", int'(kif.entry_count), 0);
    check("timeout no pulse", int'({kif.open, kif.close}), 0);
    step(1'b0, 1'b0, 1'b1, 4'd3);
    step(1'b0, 1'b0, 1'b1, 4'd4);
    enter();
    check("timeout open", int'(kif.open), 0);
    check("timeout fail_count", int'(kif.fail_count), 1);

    // Reset in the middle of lockout aborts it at once.
    for (int k = 0; k < 2; k++) begin
      digits(4'd9, 4'd9, 4'd9, 4'd9);
      enter();
    end
    check("pre-reset locked_out", int'(kif.locked_out), 1);
    idle(4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("post-reset locked_out", int'(kif.locked_out), 0);
    check("post-reset fail_count", int'(kif.fail_count), 0);
    digits(4'd1, 4'd2, 4'd3, 4'd4);
    enter();
    check("post-reset open", int'(kif.open), 1);
    idle(1);
    check("post-reset open width", int'(kif.open), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
